// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU op codes
// driven to the ALU control decoder, and main FSM state encodings.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_I_EXEC   = 4'd9,
        ST_I_WB     = 4'd10,
        ST_BEQ      = 4'd11,
        ST_JUMP     = 4'd12
    } state_t;

    function automatic logic [2:0] itype_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALUOP_AND;
            OP_ORI:  return ALUOP_OR;
            OP_SLTI: return ALUOP_SLT;
            default: return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
//   state    | meaning
//   RESET    | idle after reset, advances to FETCH
//   FETCH    | read instruction at PC, PC <= PC+4 (holds on mem wait)
//   DECODE   | read registers, precompute branch target
//   MEM_ADDR | compute lw/sw effective address
//   MEM_RD   | load data read (holds on mem wait)
//   MEM_WB   | write loaded data to rt
//   MEM_WR   | store data write (holds on mem wait)
//   R_EXEC   | R-type ALU operation
//   R_WB     | write ALU result to rd
//   I_EXEC   | immediate ALU operation
//   I_WB     | write ALU result to rt
//   BEQ      | compare and conditionally branch
//   JUMP     | load jump target
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_operation,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t     state, state_nxt;
    logic       mem_ok;
    logic       decode_illegal;
    logic [2:0] i_alu_op;

    assign mem_ok    = !MEM_WAIT_EN || mem_ready;
    assign state_dbg = state;

    always_comb begin
        state_nxt      = ST_FETCH;
        decode_illegal = 1'b0;
        case (state)
            ST_RESET:    state_nxt = ST_FETCH;
            ST_FETCH:    state_nxt = mem_ok ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                        state_nxt = ST_MEM_ADDR;
                    OP_RTYPE:                            state_nxt = ST_R_EXEC;
                    OP_BEQ:                              state_nxt = ST_BEQ;
                    OP_J:                                state_nxt = ST_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   state_nxt = ST_I_EXEC;
                    default: begin
                        state_nxt      = ST_FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: state_nxt = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   state_nxt = mem_ok ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   state_nxt = ST_FETCH;
            ST_MEM_WR:   state_nxt = mem_ok ? ST_FETCH : ST_MEM_WR;
            ST_R_EXEC:   state_nxt = ST_R_WB;
            ST_I_EXEC:   state_nxt = ST_I_WB;
            default:     state_nxt = ST_FETCH;
        endcase
    end

    // Immediate ALU op is captured in DECODE so I_EXEC ignores later IR changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RESET;
            illegal_op <= 1'b0;
            i_alu_op   <= ALUOP_ADD;
        end else begin
            state      <= state_nxt;
            illegal_op <= decode_illegal;
            if (state == ST_DECODE)
                i_alu_op <= itype_alu_op(opcode);
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_operation = ALUOP_ADD;
        case (state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ok;
                pc_write  = mem_ok;
                alu_src_b = 2'b01;
            end
            ST_DECODE:   alu_src_b = 2'b11;
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_R_EXEC: begin
                alu_src_a     = 1'b1;
                alu_operation = ALUOP_RTYPE;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_I_EXEC: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b10;
                alu_operation = i_alu_op;
            end
            ST_I_WB:     reg_write = 1'b1;
            ST_BEQ: begin
                alu_src_a     = 1'b1;
                alu_operation = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: stimulus pushes per-cycle
// expected output vectors, a negedge monitor pops and compares them.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_operation;
    logic [3:0] state_dbg;

    int errors = 0;
    int checks = 0;

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_operation(alu_operation), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal}
    localparam logic [21:0] E_RESET  = {4'd0,  10'b0000000000, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [21:0] E_FETCH  = {4'd1,  10'b1001010000, 2'b01, 2'b00, 3'b000, 1'b0};
    localparam logic [21:0] E_FWAIT  = {4'd1,  10'b0001000000, 2'b01, 2'b00, 3'b000, 1'b0};
    localparam logic [21:0] E_FILL   = {4'd1,  10'b1001010000, 2'b01, 2'b00, 3'b000, 1'b1};
    localparam logic [21:0] E_DECODE = {4'd2,  10'b0000000000, 2'b11, 2'b00, 3'b000, 1'b0};
    localparam logic [21:0] E_MADDR  = {4'd3,  10'b0000000001, 2'b10, 2'b00, 3'b000, 1'b0};
    localparam logic [21:0] E_MRD    = {4'd4,  10'b0011000000, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [21:0] E_MWB    = {4'd5,  10'b0000001010, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [21:0] E_MWR    = {4'd6,  10'b0010100000, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [21:0] E_REXEC  = {4'd7,  10'b0000000001, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [21:0] E_RWB    = {4'd8,  10'b0000000110, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [21:0] E_IWB    = {4'd10, 10'b0000000010, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [21:0] E_BEQ    = {4'd11, 10'b0100000001, 2'b00, 2'b01, 3'b001, 1'b0};
    localparam logic [21:0] E_JUMP   = {4'd12, 10'b1000000000, 2'b00, 2'b10, 3'b000, 1'b0};

    function automatic logic [21:0] e_iexec(input logic [2:0] aop);
        return {4'd9, 10'b0000000001, 2'b10, 2'b00, aop, 1'b0};
    endfunction

    typedef struct {
        logic [21:0] exp;
        int          id;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       step_id = 0;

    function automatic logic [21:0] dut_vec();
        return {state_dbg, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                pc_source, alu_operation, illegal_op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            chk($sformatf("step%0d", it.id), {10'b0, dut_vec()}, {10'b0, it.exp});
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during it.
    task automatic cyc(input logic [21:0] e, input logic [5:0] op, input logic mr);
        sb_item_t it;
        opcode    = op;
        mem_ready = mr;
        it.exp    = e;
        it.id     = step_id++;
        sb_q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cyc(E_RESET, 6'b0, 1'b1);
        rst_n = 1'b1;
        cyc(E_RESET, 6'b0, 1'b1);

        // lw, no waits: 5 cycles
        cyc(E_FETCH, 6'b100011, 1'b1);
        cyc(E_DECODE, 6'b100011, 1'b1);
        cyc(E_MADDR, 6'b100011, 1'b1);
        cyc(E_MRD, 6'b100011, 1'b1);
        cyc(E_MWB, 6'b100011, 1'b1);

        // sw with fetch wait and two memory wait cycles
        cyc(E_FWAIT, 6'b101011, 1'b0);
        cyc(E_FETCH, 6'b101011, 1'b1);
        cyc(E_DECODE, 6'b101011, 1'b1);
        cyc(E_MADDR, 6'b101011, 1'b1);
        cyc(E_MWR, 6'b101011, 1'b0);
        cyc(E_MWR, 6'b101011, 1'b0);
        cyc(E_MWR, 6'b101011, 1'b1);

        // lw with one read wait
        cyc(E_FETCH, 6'b100011, 1'b1);
        cyc(E_DECODE, 6'b100011, 1'b1);
        cyc(E_MADDR, 6'b100011, 1'b1);
        cyc(E_MRD, 6'b100011, 1'b0);
        cyc(E_MRD, 6'b100011, 1'b1);
        cyc(E_MWB, 6'b100011, 1'b1);

        // ori; opcode changes during I_EXEC, latched op must hold
        cyc(E_FETCH, 6'b001101, 1'b1);
        cyc(E_DECODE, 6'b001101, 1'b1);
        cyc(e_iexec(3'b100), 6'b000000, 1'b1);
        cyc(E_IWB, 6'b000000, 1'b1);

        // slti, andi, addi
        cyc(E_FETCH, 6'b001010, 1'b1);
        cyc(E_DECODE, 6'b001010, 1'b1);
        cyc(e_iexec(3'b101), 6'b001010, 1'b1);
        cyc(E_IWB, 6'b001010, 1'b1);
        cyc(E_FETCH, 6'b001100, 1'b1);
        cyc(E_DECODE, 6'b001100, 1'b1);
        cyc(e_iexec(3'b011), 6'b001100, 1'b1);
        cyc(E_IWB, 6'b001100, 1'b1);
        cyc(E_FETCH, 6'b001000, 1'b1);
        cyc(E_DECODE, 6'b001000, 1'b1);
        cyc(e_iexec(3'b000), 6'b001000, 1'b1);
        cyc(E_IWB, 6'b001000, 1'b1);

        // R-type
        cyc(E_FETCH, 6'b000000, 1'b1);
        cyc(E_DECODE, 6'b000000, 1'b1);
        cyc(E_REXEC, 6'b000000, 1'b1);
        cyc(E_RWB, 6'b000000, 1'b1);

        // beq, j: 3 cycles each
        cyc(E_FETCH, 6'b000100, 1'b1);
        cyc(E_DECODE, 6'b000100, 1'b1);
        cyc(E_BEQ, 6'b000100, 1'b1);
        cyc(E_FETCH, 6'b000010, 1'b1);
        cyc(E_DECODE, 6'b000010, 1'b1);
        cyc(E_JUMP, 6'b000010, 1'b1);

        // illegal opcode: one-cycle pulse in the following FETCH
        cyc(E_FETCH, 6'b111111, 1'b1);
        cyc(E_DECODE, 6'b111111, 1'b1);
        cyc(E_FILL, 6'b111111, 1'b1);
        cyc(E_DECODE, 6'b000010, 1'b1);
        cyc(E_JUMP, 6'b000010, 1'b1);

        // reset asserted mid MEM_WR while waiting on memory
        cyc(E_FETCH, 6'b101011, 1'b1);
        cyc(E_DECODE, 6'b101011, 1'b1);
        cyc(E_MADDR, 6'b101011, 1'b1);
        begin
            sb_item_t it;
            mem_ready = 1'b0;
            it.exp    = E_MWR;
            it.id     = step_id++;
            sb_q.push_back(it);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("async_rst_state", {28'b0, state_dbg}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_no_strobe", {30'b0, mem_write, reg_write}, 32'd0);
        cyc(E_RESET, 6'b101011, 1'b0);
        rst_n = 1'b1;
        cyc(E_RESET, 6'b101011, 1'b1);
        cyc(E_FETCH, 6'b000010, 1'b1);
        cyc(E_DECODE, 6'b000010, 1'b1);
        cyc(E_JUMP, 6'b000010, 1'b1);

        repeat (10) begin
            if (sb_q.size() > 0) @(negedge clk);
        end
        #1;
        chk("scoreboard_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
